// File: rtl/ahb_master_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_master_req_arbiter_if
// Description : Bundles the requester-side (I-cache, D-cache, peripheral LSU)
//               and master-side signals of ahb_master_req_arbiter.
//               modport master : view taken by the arbiter itself
//               modport slave  : view taken by the surrounding requesters and
//                                the AHB master (testbench / integration)
// Signals     : i_req/i_addr/i_ready           I-cache line fill
//               d_req/d_write/d_addr/d_wdata/d_ready  D-cache fill/writeback
//               p_req/p_write/p_addr/p_wdata/p_ready  peripheral single access
//               rdata                           read data broadcast
//               m_addr/m_write/m_wdata/m_transfer  to AHB master
//               m_rdata/m_ready                 from AHB master
//               gnt                             one-hot owner {p,d,i}
// Revision    : 1.0 - initial release
// ============================================================================
interface ahb_master_req_arbiter_if;

  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;

  logic        d_req;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;

  logic        p_req;
  logic        p_write;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  logic        p_ready;

  logic [31:0] rdata;

  logic [31:0] m_addr;
  logic        m_write;
  logic [31:0] m_wdata;
  logic [1:0]  m_transfer;
  logic [31:0] m_rdata;
  logic        m_ready;

  logic [2:0]  gnt;

  modport master (
    input  i_req, i_addr,
    input  d_req, d_write, d_addr, d_wdata,
    input  p_req, p_write, p_addr, p_wdata,
    input  m_rdata, m_ready,
    output i_ready, d_ready, p_ready, rdata,
    output m_addr, m_write, m_wdata, m_transfer, gnt
  );

  modport slave (
    output i_req, i_addr,
    output d_req, d_write, d_addr, d_wdata,
    output p_req, p_write, p_addr, p_wdata,
    output m_rdata, m_ready,
    input  i_ready, d_ready, p_ready, rdata,
    input  m_addr, m_write, m_wdata, m_transfer, gnt
  );

endinterface
`default_nettype wire

// File: rtl/ahb_master_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ahb_master_req_arbiter
// Description : Shares the single AHB master processor-side port between the
//               I-cache (burst read), D-cache (burst fill/writeback) and the
//               uncached peripheral path (single beat). Arbitrates in IDLE,
//               issues a one-cycle transfer request, then holds the grant and
//               steers address/data/ready until all beats have completed.
// Ports       : HCLK      clock
//               HRESETn   asynchronous active-low reset
//               bus       ahb_master_req_arbiter_if.master (all bus signals)
// Parameters  : BURST_BEATS  beats per cache line transfer (>= 2)
//               CNT_W        beat counter width, 2**CNT_W > BURST_BEATS
// Options     : AHB_ARB_ROUND_ROBIN_EN  rotating priority I -> D -> P,
//               pointer resets to I-highest. Undefined: fixed D > I > P.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_master_req_arbiter #(
  parameter int BURST_BEATS = 8,
  parameter int CNT_W       = 4
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  ahb_master_req_arbiter_if.master  bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_xfer_none = 2'd0;
  localparam logic [1:0] c_xfer_i    = 2'd1;
  localparam logic [1:0] c_xfer_d    = 2'd2;
  localparam logic [1:0] c_xfer_p    = 2'd3;

  localparam logic [2:0] c_gnt_none  = 3'b000;
  localparam logic [2:0] c_gnt_i     = 3'b001;
  localparam logic [2:0] c_gnt_d     = 3'b010;
  localparam logic [2:0] c_gnt_p     = 3'b100;

  localparam logic [CNT_W-1:0] c_cnt_zero  = '0;
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(BURST_BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  // Returns the first of three one-hot candidates (in priority order) that
  // has its request bit set; zero when nobody is requesting.
  function automatic logic [2:0] f_pick3(
    input logic [2:0] req,
    input logic [2:0] first,
    input logic [2:0] second,
    input logic [2:0] third
  );
    if ((req & first) != c_gnt_none) begin
      return first;
    end
    if ((req & second) != c_gnt_none) begin
      return second;
    end
    if ((req & third) != c_gnt_none) begin
      return third;
    end
    return c_gnt_none;
  endfunction

  function automatic logic [1:0] f_code(input logic [2:0] onehot);
    case (onehot)
      c_gnt_i: return c_xfer_i;
      c_gnt_d: return c_xfer_d;
      c_gnt_p: return c_xfer_p;
      default: return c_xfer_none;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           r_state;
  logic [2:0]       r_gnt;
  logic [1:0]       r_transfer;
  logic [CNT_W-1:0] r_cnt;

  logic [2:0]       w_req;
  logic [2:0]       w_win;
  logic             w_beat;
  logic             w_last;
  logic             w_steer;

  assign w_req = {bus.p_req, bus.d_req, bus.i_req};

  // --------------------------------------------------------------------------
  // Arbitration (only consumed while IDLE)
  // --------------------------------------------------------------------------
`ifdef AHB_ARB_ROUND_ROBIN_EN
  // One-hot {p,d,i}: the requester that currently has highest priority.
  logic [2:0] r_rr_top;

  always_comb begin
    w_win = c_gnt_none;
    case (r_rr_top)
      c_gnt_d: w_win = f_pick3(w_req, c_gnt_d, c_gnt_p, c_gnt_i);
      c_gnt_p: w_win = f_pick3(w_req, c_gnt_p, c_gnt_i, c_gnt_d);
      default: w_win = f_pick3(w_req, c_gnt_i, c_gnt_d, c_gnt_p);
    endcase
  end

  // After owner X completes, the requester following X in the cycle
  // I -> D -> P -> I becomes highest, which leaves X lowest. With the
  // {p,d,i} bit order that is a rotate-left of the finishing grant.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rr_top <= c_gnt_i;
    end else if (w_beat && w_last) begin
      r_rr_top <= {r_gnt[1:0], r_gnt[2]};
    end
  end
`else
  always_comb begin
    w_win = f_pick3(w_req, c_gnt_d, c_gnt_i, c_gnt_p);
  end
`endif

  // --------------------------------------------------------------------------
  // Beat accounting
  // --------------------------------------------------------------------------
  // m_ready only counts while BUSY; strays in IDLE/ISSUE/DONE are dropped.
  assign w_beat = (r_state == ST_BUSY) && bus.m_ready;
  // The peripheral path is a single beat; bursts end on the last counted beat.
  assign w_last = (r_gnt == c_gnt_p) || (r_cnt == c_last_beat);

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= ST_IDLE;
      r_gnt      <= c_gnt_none;
      r_transfer <= c_xfer_none;
      r_cnt      <= c_cnt_zero;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_win != c_gnt_none) begin
            r_gnt      <= w_win;
            r_transfer <= f_code(w_win);
            r_cnt      <= c_cnt_zero;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // The master latches address/control in this single cycle.
          r_transfer <= c_xfer_none;
          r_cnt      <= c_cnt_zero;
          r_state    <= ST_BUSY;
        end
        ST_BUSY: begin
          if (w_beat) begin
            r_cnt <= r_cnt + c_cnt_one;
            if (w_last) begin
              r_gnt   <= c_gnt_none;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_gnt      <= c_gnt_none;
          r_transfer <= c_xfer_none;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Steering
  // --------------------------------------------------------------------------
  // Address/data follow the owner's live inputs so a writeback can present a
  // new data word on every beat; outside ISSUE/BUSY everything reads zero.
  assign w_steer = (r_state == ST_ISSUE) || (r_state == ST_BUSY);

  logic [31:0] w_m_addr;
  logic        w_m_write;
  logic [31:0] w_m_wdata;

  always_comb begin
    w_m_addr  = 32'h0;
    w_m_write = 1'b0;
    w_m_wdata = 32'h0;
    if (w_steer) begin
      case (r_gnt)
        c_gnt_i: begin
          w_m_addr  = bus.i_addr;
        end
        c_gnt_d: begin
          w_m_addr  = bus.d_addr;
          w_m_write = bus.d_write;
          w_m_wdata = bus.d_wdata;
        end
        c_gnt_p: begin
          w_m_addr  = bus.p_addr;
          w_m_write = bus.p_write;
          w_m_wdata = bus.p_wdata;
        end
        default: begin
          w_m_addr  = 32'h0;
        end
      endcase
    end
  end

  assign bus.m_addr     = w_m_addr;
  assign bus.m_write    = w_m_write;
  assign bus.m_wdata    = w_m_wdata;
  assign bus.m_transfer = r_transfer;
  assign bus.gnt        = r_gnt;

  assign bus.i_ready    = w_beat && r_gnt[0];
  assign bus.d_ready    = w_beat && r_gnt[1];
  assign bus.p_ready    = w_beat && r_gnt[2];

  assign bus.rdata      = bus.m_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_master_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_master_req_arbiter
// Description : Self-checking bench for ahb_master_req_arbiter. Expected
//               issue records and beat records are queued when stimulus is
//               driven and popped by a monitor when the DUT shows them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_master_req_arbiter;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;

  ahb_master_req_arbiter_if bus ();

  ahb_master_req_arbiter #(
    .BURST_BEATS (8),
    .CNT_W       (4)
  ) u_dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [1:0]  code;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } iss_t;

  typedef struct {
    logic [2:0]  vec;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [31:0] addr;
  } beat_t;

  iss_t  issue_q[$];
  beat_t beat_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] code2vec(input logic [1:0] c);
    case (c)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic push_issue(input logic [1:0] code, input logic [31:0] addr,
                            input logic wr, input logic [31:0] wdata);
    iss_t e;
    e.code = code; e.addr = addr; e.wr = wr; e.wdata = wdata;
    issue_q.push_back(e);
  endtask

  // --------------------------------------------------------------------------
  // Monitor: samples on the falling edge
  // --------------------------------------------------------------------------
  always @(negedge HCLK) begin
    iss_t  ie;
    beat_t be;
    logic [2:0] rdy;
    if (HRESETn) begin
      if (bus.m_transfer != 2'd0) begin
        if (issue_q.size() == 0) begin
          check("unexpected_issue", {30'h0, bus.m_transfer}, 32'h0);
        end else begin
          ie = issue_q.pop_front();
          check("issue_code",  {30'h0, bus.m_transfer}, {30'h0, ie.code});
          check("issue_addr",  bus.m_addr, ie.addr);
          check("issue_write", {31'h0, bus.m_write}, {31'h0, ie.wr});
          check("issue_wdata", bus.m_wdata, ie.wdata);
          check("issue_gnt",   {29'h0, bus.gnt}, {29'h0, code2vec(ie.code)});
        end
      end
      rdy = {bus.p_ready, bus.d_ready, bus.i_ready};
      if (rdy != 3'b000) begin
        if (beat_q.size() == 0) begin
          check("unexpected_ready", {29'h0, rdy}, 32'h0);
        end else begin
          be = beat_q.pop_front();
          check("beat_ready", {29'h0, rdy}, {29'h0, be.vec});
          check("beat_gnt",   {29'h0, bus.gnt}, {29'h0, be.vec});
          check("beat_rdata", bus.rdata, be.rdata);
          check("beat_wdata", bus.m_wdata, be.wdata);
          check("beat_addr",  bus.m_addr, be.addr);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic check_zero_outputs(input string tag);
    check({tag, "_gnt"},   {29'h0, bus.gnt}, 32'h0);
    check({tag, "_xfer"},  {30'h0, bus.m_transfer}, 32'h0);
    check({tag, "_addr"},  bus.m_addr, 32'h0);
    check({tag, "_write"}, {31'h0, bus.m_write}, 32'h0);
    check({tag, "_wdata"}, bus.m_wdata, 32'h0);
    check({tag, "_ready"}, {29'h0, bus.p_ready, bus.d_ready, bus.i_ready}, 32'h0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge HCLK); #3;
    HRESETn     = 1'b0;
    bus.m_ready = 1'b1;
    #1;
    check_zero_outputs(tag);
    @(posedge HCLK); #2;
    bus.m_ready = 1'b0;
    #1;
    HRESETn     = 1'b1;
  endtask

  // Waits for the ISSUE cycle, then feeds `beats` m_ready pulses during BUSY.
  // waited = falling edges from the call up to and including the ISSUE cycle.
  task automatic serve(input int beats, input logic [2:0] vec, input logic [31:0] addr,
                       input logic [31:0] base, input bit drive_dw, input logic [31:0] wd,
                       input bit gaps, input bit complete, output int waited);
    bit    seen;
    beat_t be;
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < 40) begin
      @(negedge HCLK);
      waited++;
      if (bus.m_transfer != 2'd0) seen = 1'b1;
    end
    check("issue_seen", {31'h0, seen}, 32'h1);
    if (!seen) return;
    for (int b = 0; b < beats; b++) begin
      @(posedge HCLK); #1;
      if (gaps && (b % 3 == 1)) begin
        bus.m_ready = 1'b0;
        @(posedge HCLK); #1;
      end
      bus.m_rdata = base + b;
      if (drive_dw) bus.d_wdata = base + b;
      be.vec   = vec;
      be.rdata = base + b;
      be.wdata = drive_dw ? (base + b) : wd;
      be.addr  = addr;
      beat_q.push_back(be);
      bus.m_ready = 1'b1;
    end
    @(posedge HCLK); #1;
    bus.m_ready = 1'b0;
    if (complete) begin
      check("done_gnt",  {29'h0, bus.gnt}, 32'h0);
      check("done_xfer", {30'h0, bus.m_transfer}, 32'h0);
      check("done_addr", bus.m_addr, 32'h0);
    end
  endtask

  // One leg of the three-way contention test; who: 0=I, 1=D, 2=P.
  task automatic leg(input int who, input int exp_wait);
    int w;
    case (who)
      0: begin
        serve(8, 3'b001, 32'h0000_2000, 32'h1000_0000, 1'b0, 32'h0, 1'b0, 1'b1, w);
        bus.i_req = 1'b0;
      end
      1: begin
        serve(8, 3'b010, 32'h2000_1000, 32'h2000_0000, 1'b0, 32'h0, 1'b0, 1'b1, w);
        bus.d_req = 1'b0;
      end
      default: begin
        serve(1, 3'b100, 32'h4000_0010, 32'h3000_0000, 1'b0, 32'h0, 1'b0, 1'b1, w);
        bus.p_req = 1'b0;
      end
    endcase
    check("contention_wait", w, exp_wait);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int w;
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_write = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    bus.p_req = 1'b0; bus.p_write = 1'b0; bus.p_addr = 32'h0; bus.p_wdata = 32'h0;
    bus.m_rdata = 32'h0;
    bus.m_ready = 1'b1;

    // Reset state
    #3;
    check_zero_outputs("reset");
    @(posedge HCLK); #3;
    bus.m_ready = 1'b0;
    HRESETn     = 1'b1;

    // rdata is a plain pass-through
    @(posedge HCLK); #1;
    bus.m_rdata = 32'h1234_5678;
    #1;
    check("rdata_comb", bus.rdata, 32'h1234_5678);

    // Stray m_ready in IDLE and through ISSUE, then an I-cache fill
    @(posedge HCLK); #1;
    bus.m_ready = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_1000;
    push_issue(2'd1, 32'h0000_1000, 1'b0, 32'h0);
    serve(8, 3'b001, 32'h0000_1000, 32'h1111_0000, 1'b0, 32'h0, 1'b1, 1'b1, w);
    check("i_latency", w, 2);
    bus.i_req = 1'b0;
    repeat (2) @(posedge HCLK);

    // D-cache writeback, data A0..A7
    #1;
    bus.d_req = 1'b1; bus.d_write = 1'b1;
    bus.d_addr = 32'h2000_0040; bus.d_wdata = 32'h0000_00A0;
    push_issue(2'd2, 32'h2000_0040, 1'b1, 32'h0000_00A0);
    serve(8, 3'b010, 32'h2000_0040, 32'h0000_00A0, 1'b1, 32'h0, 1'b1, 1'b1, w);
    check("d_latency", w, 2);
    bus.d_req = 1'b0; bus.d_write = 1'b0;
    repeat (2) @(posedge HCLK);

    // Peripheral read, then a peripheral write with req held across DONE
    #1;
    bus.p_req = 1'b1; bus.p_write = 1'b0;
    bus.p_addr = 32'h4000_0004; bus.p_wdata = 32'h0;
    push_issue(2'd3, 32'h4000_0004, 1'b0, 32'h0);
    serve(1, 3'b100, 32'h4000_0004, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 1'b1, w);
    check("p_latency", w, 2);
    bus.p_write = 1'b1; bus.p_addr = 32'h4000_0008; bus.p_wdata = 32'h5555_AAAA;
    push_issue(2'd3, 32'h4000_0008, 1'b1, 32'h5555_AAAA);
    serve(1, 3'b100, 32'h4000_0008, 32'h0BAD_F00D, 1'b0, 32'h5555_AAAA, 1'b0, 1'b1, w);
    check("p_back_to_back_gap", w, 3);
    bus.p_req = 1'b0; bus.p_write = 1'b0; bus.p_wdata = 32'h0;
    repeat (2) @(posedge HCLK);

    // Three-way contention from a fresh reset
    do_reset("rst_pre_contention");
    @(posedge HCLK); #1;
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_2000;
    bus.d_req = 1'b1; bus.d_write = 1'b0; bus.d_addr = 32'h2000_1000; bus.d_wdata = 32'h0;
    bus.p_req = 1'b1; bus.p_write = 1'b0; bus.p_addr = 32'h4000_0010; bus.p_wdata = 32'h0;
`ifdef AHB_ARB_ROUND_ROBIN_EN
    push_issue(2'd1, 32'h0000_2000, 1'b0, 32'h0);
    push_issue(2'd2, 32'h2000_1000, 1'b0, 32'h0);
    push_issue(2'd3, 32'h4000_0010, 1'b0, 32'h0);
    leg(0, 2);
    leg(1, 3);
    leg(2, 3);
`else
    push_issue(2'd2, 32'h2000_1000, 1'b0, 32'h0);
    push_issue(2'd1, 32'h0000_2000, 1'b0, 32'h0);
    push_issue(2'd3, 32'h4000_0010, 1'b0, 32'h0);
    leg(1, 2);
    leg(0, 3);
    leg(2, 3);
`endif
    repeat (2) @(posedge HCLK);

    // Reset after 3 of 8 D-cache beats, then a fresh transfer
    #1;
    bus.d_req = 1'b1; bus.d_write = 1'b0;
    bus.d_addr = 32'h3000_0080; bus.d_wdata = 32'h0000_0077;
    push_issue(2'd2, 32'h3000_0080, 1'b0, 32'h0000_0077);
    serve(3, 3'b010, 32'h3000_0080, 32'h5000_0000, 1'b0, 32'h0000_0077, 1'b0, 1'b0, w);
    do_reset("rst_mid_burst");
    push_issue(2'd2, 32'h3000_0080, 1'b0, 32'h0000_0077);
    serve(8, 3'b010, 32'h3000_0080, 32'h6000_0000, 1'b0, 32'h0000_0077, 1'b1, 1'b1, w);
    check("post_reset_latency", w, 2);
    bus.d_req = 1'b0;
    repeat (4) @(posedge HCLK);

    check("issue_q_left", issue_q.size(), 0);
    check("beat_q_left",  beat_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ahb_master_req_arbiter.md
Name: ahb_master_req_arbiter

Overview:
- Shares the single AHB master processor-side port between three requesters: I-cache line fill, D-cache line fill/writeback, and uncached peripheral access.
- Arbitrates, drives a one-cycle transfer request into the master, then holds the grant and steers address/data/ready until the transaction's beats complete.
- Sits between the cache/LSU front end and the AHB master.

Parameters:
- BURST_BEATS, 8, data beats per cache transfer (INCR8 line); must be at least 2.
- CNT_W, 4, beat counter width; must satisfy 2^CNT_W > BURST_BEATS.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- i_req  in  1  I-cache fill request (burst read)
- i_addr  in  32  I-cache line address
- i_ready  out  1  beat strobe to I-cache
- d_req  in  1  D-cache request (burst)
- d_write  in  1  1 = writeback, 0 = fill
- d_addr  in  32  D-cache line address
- d_wdata  in  32  D-cache write beat data
- d_ready  out  1  beat strobe to D-cache
- p_req  in  1  peripheral single access request
- p_write  in  1  peripheral write
- p_addr  in  32  peripheral address
- p_wdata  in  32  peripheral write data
- p_ready  out  1  completion strobe to LSU
- rdata  out  32  read data broadcast to all requesters; valid when the requester's own ready strobe is high
- m_addr  out  32  to master addr
- m_write  out  1  to master write
- m_wdata  out  32  to master wdata
- m_transfer  out  2  to master transfer: 0 none, 1 I-cache, 2 D-cache, 3 peripheral
- m_rdata  in  32  from master rdata
- m_ready  in  1  from master ready
- gnt  out  3  one-hot current owner {p,d,i}; 0 when idle

Behaviour:
- Reset (HRESETn low, asynchronous): state IDLE; gnt=0; m_transfer=0; m_addr=0; m_write=0; m_wdata=0; beat counter=0; all x_ready=0. Applies immediately, including mid-transaction. No transfer is replayed after reset.
- FSM states: IDLE, ISSUE, BUSY, DONE.
- IDLE:
  - Any request high -> registered arbitration, then ISSUE.
  - Default priority is fixed: D > I > P.
  - m_transfer=0 and all steering outputs are 0.
- ISSUE (exactly 1 cycle):
  - m_transfer = owner code 1/2/3.
  - m_addr = owner addr; m_write = d_write or p_write (0 for I-cache); m_wdata = owner wdata.
  - Counter cleared. Next state BUSY.
- BUSY:
  - m_transfer=0; m_addr, m_write and m_wdata keep tracking the owner's live inputs.
  - Owner's x_ready = m_ready. Non-owners' ready = 0.
  - Each m_ready pulse increments the counter.
  - Burst owners (I, D) complete on pulse number BURST_BEATS. Peripheral owner completes on its 1st pulse.
  - Completion -> DONE.
- DONE (1 cycle turnaround): gnt cleared, steering outputs 0, then IDLE. Back-to-back grants are therefore separated by at least one IDLE cycle.
- rdata = m_rdata combinationally at all times.
- Latency: a request sampled in IDLE at cycle N gives m_transfer valid at N+1 and the first ready no earlier than N+2.
- Requester contract: hold req, addr, write and wdata stable from assertion until your final ready beat.
  - Dropping req mid-grant is ignored; the grant runs to completion.
  - Changing addr mid-BUSY has no effect on the bus, because the master already latched it at ISSUE.
- Simultaneous requests: arbitration happens only in IDLE. Losers stay pending with ready=0; no queueing beyond the req level.
- m_ready seen in IDLE, ISSUE or DONE: ignored, not forwarded, not counted.
- The counter never exceeds BURST_BEATS; it is cleared on every ISSUE.

Optional Feature:
- Macro AHB_ARB_ROUND_ROBIN_EN.
- Defined: rotating priority. After a grant to owner X completes, X becomes lowest priority; the order cycles I -> D -> P -> I. The rotation pointer resets to I-highest (I > D > P).
- Undefined: fixed priority D > I > P; no pointer register is synthesized.

Test Plan:
- I-cache alone: i_req=1, i_addr=0x0000_1000; m_ready pulses 8 times -> m_transfer=1 for one cycle, i_ready pulses 8 times, gnt=001 throughout BUSY, then DONE and IDLE.
- D-cache writeback: d_req=1, d_write=1, d_addr=0x2000_0040, d_wdata sequence 0xA0..0xA7 -> m_transfer=2, m_write=1, m_wdata follows d_wdata each cycle, completion after 8 ready pulses.
- Peripheral read: p_req=1, p_addr=0x4000_0004, m_rdata=0xDEAD_BEEF with a single ready pulse -> p_ready=1 that cycle, rdata=0xDEAD_BEEF, return to IDLE 2 cycles later.
- Contention: i_req, d_req and p_req raised in the same cycle -> order D, I, P in fixed mode; order I, D, P in AHB_ARB_ROUND_ROBIN_EN mode from reset; at least 1 IDLE cycle between grants.
- Reset mid-burst: HRESETn low after 3 of 8 D beats -> all outputs 0 immediately; after release with d_req still high -> fresh ISSUE with m_transfer=2 and counter restarting at 0.
- Stray ready: m_ready=1 while IDLE and during ISSUE -> no x_ready pulse, counter unchanged, transaction still needs the full 8 BUSY beats.
